// File: rtl/spw_light_status_in.sv
// -----------------------------------------------------------------------------
// spw_light_status_in
//
// CPU-side Avalon-MM input port for SpaceWire light link status and event
// lines. The asynchronous in_port lines are brought into clk through a
// two-flop synchroniser, per-bit edges are latched into a sticky capture
// register, and a level interrupt is raised while any unmasked capture is
// pending. Software clears captures by writing 1s to EDGE_CAPTURE.
//
// Register map (word addresses):
//   0 DATA         read-only synchronised level
//   1 reserved     reads 0, writes ignored
//   2 IRQ_MASK     read/write, WIDTH bits
//   3 EDGE_CAPTURE read, write-1-to-clear
//
// Ports:
//   clk         sole clock
//   reset       synchronous, active-high reset
//   address     register select (word address)
//   chipselect  slave select
//   write_n     active-low write strobe
//   writedata   write data (bits above WIDTH ignored)
//   in_port     asynchronous status/event lines
//   readdata    registered read data, one cycle latency
//   irq         registered level interrupt
// -----------------------------------------------------------------------------
module spw_light_status_in #(
    parameter int WIDTH     = 8,
    parameter int EDGE_TYPE = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_RSVD = 2'd1;
    localparam logic [1:0] ADDR_MASK = 2'd2;
    localparam logic [1:0] ADDR_CAP  = 2'd3;

    // Edge vector for the configured capture mode; unknown modes act as any-edge.
    function automatic logic [WIDTH-1:0] edge_detect(
        input logic [WIDTH-1:0] cur,
        input logic [WIDTH-1:0] old
    );
        logic [WIDTH-1:0] ev;
        case (EDGE_TYPE)
            32'sd0:  ev = cur & ~old;
            32'sd1:  ev = ~cur & old;
            default: ev = cur ^ old;
        endcase
        return ev;
    endfunction

    // Zero-extend a WIDTH-bit register to the 32-bit bus.
    function automatic logic [31:0] zext(input logic [WIDTH-1:0] v);
        logic [31:0] r;
        r = 32'd0;
        r[WIDTH-1:0] = v;
        return r;
    endfunction

    logic [WIDTH-1:0] sync1_q, sync2_q, prev_q;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [WIDTH-1:0] cap_q, cap_d;
    logic [31:0]      readdata_q, readdata_d;
    logic             irq_q, irq_d;

    logic             wr_en_s;
    logic [WIDTH-1:0] wr_data_s;
    logic [WIDTH-1:0] ev_s;
    logic [WIDTH-1:0] clr_s;
    logic [31:0]      rd_mux_s;

    // Upper writedata bits are don't-care when WIDTH < 32.
    logic             unused_wdata_s;
    assign unused_wdata_s = ^writedata;

    // Next-state logic for mask, capture, read data and interrupt.
    always_comb begin
        wr_en_s    = chipselect & ~write_n;
        wr_data_s  = writedata[WIDTH-1:0];
        ev_s       = edge_detect(sync2_q, prev_q);
        clr_s      = '0;
        mask_d     = mask_q;
        rd_mux_s   = 32'd0;
        readdata_d = 32'd0;

        if (wr_en_s && (address == ADDR_CAP)) begin
            clr_s = wr_data_s;
        end else begin
            clr_s = '0;
        end

        // A new edge overrides a same-cycle clear so no event is lost.
        cap_d = ev_s | (cap_q & ~clr_s);

        if (wr_en_s && (address == ADDR_MASK)) begin
            mask_d = wr_data_s;
        end else begin
            mask_d = mask_q;
        end

        case (address)
            ADDR_DATA: rd_mux_s = zext(sync2_q);
            ADDR_RSVD: rd_mux_s = 32'd0;
            ADDR_MASK: rd_mux_s = zext(mask_q);
            ADDR_CAP:  rd_mux_s = zext(cap_q);
            default:   rd_mux_s = 32'd0;
        endcase

        // Reads are driven by chipselect alone; write_n is deliberately ignored.
        if (chipselect) begin
            readdata_d = rd_mux_s;
        end else begin
            readdata_d = 32'd0;
        end

        irq_d = |(cap_q & mask_q);
    end

    // Synchroniser, edge history and register state with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            prev_q     <= '0;
            mask_q     <= '0;
            cap_q      <= '0;
            readdata_q <= 32'd0;
            irq_q      <= 1'b0;
        end else begin
            sync1_q    <= in_port;
            sync2_q    <= sync1_q;
            prev_q     <= sync2_q;
            mask_q     <= mask_d;
            cap_q      <= cap_d;
            readdata_q <= readdata_d;
            irq_q      <= irq_d;
        end
    end

    assign readdata = readdata_q;
    assign irq      = irq_q;

endmodule

// File: tb/tb_spw_light_status_in.sv
module tb_spw_light_status_in;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [7:0]  in_port;

    logic [31:0] rd [3];
    logic [2:0]  irq_v;

    int checks   = 0;
    int failures = 0;

    // Reference model state: in_port history (h1 = value at last edge,
    // h2 = two edges ago = visible level, h3 = three edges ago).
    logic [7:0]  h1 = 8'd0, h2 = 8'd0, h3 = 8'd0;
    logic [7:0]  m_mask = 8'd0;
    logic [7:0]  m_cap [3];
    logic [31:0] m_rd [3];
    logic [2:0]  m_irq = 3'd0;

    always #5 clk = ~clk;

    spw_light_status_in #(.WIDTH(8), .EDGE_TYPE(0)) dut_rise (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(rd[0]), .irq(irq_v[0]));

    spw_light_status_in #(.WIDTH(8), .EDGE_TYPE(1)) dut_fall (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(rd[1]), .irq(irq_v[1]));

    spw_light_status_in #(.WIDTH(8), .EDGE_TYPE(2)) dut_any (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(rd[2]), .irq(irq_v[2]));

    initial begin
        #2000000;
        $display("FAIL timeout reached without finishing");
        $fatal(1, "timeout");
    end

    // Advance one clock edge, updating the model from the inputs held across it.
    task automatic tick();
        logic       wr;
        logic [7:0] ev;
        logic [7:0] val;
        @(posedge clk);
        if (reset) begin
            h1 = 8'd0; h2 = 8'd0; h3 = 8'd0;
            m_mask = 8'd0;
            m_irq  = 3'd0;
            for (int m = 0; m < 3; m++) begin
                m_cap[m] = 8'd0;
                m_rd[m]  = 32'd0;
            end
        end else begin
            wr = chipselect && !write_n;
            for (int m = 0; m < 3; m++) begin
                if (m == 0)      ev = h2 & ~h3;
                else if (m == 1) ev = ~h2 & h3;
                else             ev = h2 ^ h3;
                case (address)
                    2'd0:    val = h2;
                    2'd2:    val = m_mask;
                    2'd3:    val = m_cap[m];
                    default: val = 8'd0;
                endcase
                m_rd[m]  = chipselect ? {24'd0, val} : 32'd0;
                m_irq[m] = |(m_cap[m] & m_mask);
                if (wr && address == 2'd3)
                    m_cap[m] = ev | (m_cap[m] & ~writedata[7:0]);
                else
                    m_cap[m] = ev | m_cap[m];
            end
            if (wr && address == 2'd2) m_mask = writedata[7:0];
            h3 = h2; h2 = h1; h1 = in_port;
        end
        #1;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic do_write(input logic [1:0] a, input logic [31:0] d);
        chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
        tick();
        chipselect = 1'b0; write_n = 1'b1; writedata = 32'd0;
    endtask

    task automatic do_read(input logic [1:0] a);
        chipselect = 1'b1; write_n = 1'b1; address = a;
        tick();
        chipselect = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; in_port = 8'h00;
        ticks(3);
        checks++;
        if (rd[0] !== 32'd0) begin
            failures++; $display("FAIL reset_readdata got=%h exp=%h", rd[0], 32'd0);
        end
        checks++;
        if (irq_v !== 3'b000) begin
            failures++; $display("FAIL reset_irq got=%b exp=%b", irq_v, 3'b000);
        end
        reset = 1'b0;
        for (int a = 0; a < 4; a++) begin
            do_read(2'(a));
            checks++;
            if (rd[0] !== 32'd0) begin
                failures++; $display("FAIL reset_read_addr%0d got=%h exp=%h", a, rd[0], 32'd0);
            end
        end
    endtask

    task automatic test_rising_irq();
        do_write(2'd2, 32'h05);
        in_port = 8'h01;
        ticks(3);                       // E0, E1, E2
        checks++;
        if (irq_v[0] !== 1'b0) begin
            failures++; $display("FAIL rise_irq_early got=%b exp=0", irq_v[0]);
        end
        do_read(2'd3);                  // E3: sees capture set at E2
        checks++;
        if (rd[0] !== 32'h01) begin
            failures++; $display("FAIL rise_capture got=%h exp=%h", rd[0], 32'h01);
        end
        checks++;
        if (irq_v[0] !== 1'b1) begin
            failures++; $display("FAIL rise_irq_E3 got=%b exp=1", irq_v[0]);
        end
        do_read(2'd0);
        checks++;
        if (rd[0] !== 32'h01) begin
            failures++; $display("FAIL rise_data got=%h exp=%h", rd[0], 32'h01);
        end
        do_write(2'd3, 32'h01);
        checks++;
        if (irq_v[0] !== 1'b1) begin
            failures++; $display("FAIL clear_irq_N got=%b exp=1", irq_v[0]);
        end
        tick();
        checks++;
        if (irq_v[0] !== 1'b0) begin
            failures++; $display("FAIL clear_irq_N1 got=%b exp=0", irq_v[0]);
        end
        do_read(2'd3);
        checks++;
        if (rd[0] !== 32'd0) begin
            failures++; $display("FAIL clear_capture got=%h exp=%h", rd[0], 32'd0);
        end
        for (int m = 1; m < 3; m++) begin
            checks++;
            if (rd[m] !== m_rd[m] || irq_v[m] !== m_irq[m]) begin
                failures++;
                $display("FAIL rise_model_dut%0d got=%h/%b exp=%h/%b", m, rd[m], irq_v[m], m_rd[m], m_irq[m]);
            end
        end
    endtask

    task automatic test_masked();
        in_port = 8'h00;
        ticks(4);
        in_port = 8'h02;
        ticks(4);
        do_read(2'd3);
        checks++;
        if (rd[0] !== 32'h02) begin
            failures++; $display("FAIL masked_capture got=%h exp=%h", rd[0], 32'h02);
        end
        checks++;
        if (irq_v[0] !== 1'b0) begin
            failures++; $display("FAIL masked_irq got=%b exp=0", irq_v[0]);
        end
        do_write(2'd2, 32'h02);
        checks++;
        if (irq_v[0] !== 1'b0) begin
            failures++; $display("FAIL unmask_irq_N got=%b exp=0", irq_v[0]);
        end
        tick();
        checks++;
        if (irq_v[0] !== 1'b1) begin
            failures++; $display("FAIL unmask_irq_N1 got=%b exp=1", irq_v[0]);
        end
        checks++;
        if (irq_v[1] !== m_irq[1]) begin
            failures++; $display("FAIL masked_fall_irq got=%b exp=%b", irq_v[1], m_irq[1]);
        end
    endtask

    task automatic test_collision();
        do_write(2'd3, 32'hFF);
        in_port = 8'h0A;                // new rise on bit 3
        ticks(2);                       // E0, E1
        do_write(2'd3, 32'hFF);         // clear lands on E2 with the edge
        do_read(2'd3);
        checks++;
        if (rd[0] !== 32'h08) begin
            failures++; $display("FAIL collision_capture got=%h exp=%h", rd[0], 32'h08);
        end
        for (int m = 1; m < 3; m++) begin
            checks++;
            if (rd[m] !== m_rd[m]) begin
                failures++; $display("FAIL collision_dut%0d got=%h exp=%h", m, rd[m], m_rd[m]);
            end
        end
    endtask

    task automatic test_modes();
        in_port = 8'hFF;
        ticks(4);
        do_write(2'd3, 32'hFF);
        in_port = 8'hF0;
        ticks(4);
        do_read(2'd3);
        checks++;
        if (rd[1] !== 32'h0F) begin
            failures++; $display("FAIL fall_capture got=%h exp=%h", rd[1], 32'h0F);
        end
        checks++;
        if (rd[2] !== 32'h0F) begin
            failures++; $display("FAIL any_fall_capture got=%h exp=%h", rd[2], 32'h0F);
        end
        checks++;
        if (rd[0] !== 32'h00) begin
            failures++; $display("FAIL rise_on_fall got=%h exp=%h", rd[0], 32'h00);
        end
        in_port = 8'h00;
        ticks(4);
        do_write(2'd3, 32'hFF);
        in_port = 8'h80;
        ticks(2);
        in_port = 8'h00;
        ticks(4);
        do_read(2'd3);
        for (int m = 0; m < 3; m++) begin
            checks++;
            if (rd[m] !== 32'h80) begin
                failures++; $display("FAIL pulse2_dut%0d got=%h exp=%h", m, rd[m], 32'h80);
            end
        end
    endtask

    task automatic test_reset_mid();
        in_port = 8'h00;
        ticks(4);
        do_write(2'd3, 32'hFF);
        do_write(2'd2, 32'hFF);
        in_port = 8'h0A;
        ticks(4);
        checks++;
        if (irq_v[0] !== 1'b1) begin
            failures++; $display("FAIL mid_irq_before got=%b exp=1", irq_v[0]);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (irq_v[0] !== 1'b0 || rd[0] !== 32'd0) begin
            failures++; $display("FAIL mid_reset got=%b/%h exp=0/0", irq_v[0], rd[0]);
        end
        do_read(2'd3);
        checks++;
        if (rd[0] !== 32'd0) begin
            failures++; $display("FAIL mid_capture_cleared got=%h exp=0", rd[0]);
        end
        do_read(2'd2);
        checks++;
        if (rd[0] !== 32'd0) begin
            failures++; $display("FAIL mid_mask_cleared got=%h exp=0", rd[0]);
        end
        ticks(2);
        do_read(2'd3);
        checks++;
        if (rd[0] !== 32'h0A) begin
            failures++; $display("FAIL mid_recapture got=%h exp=%h", rd[0], 32'h0A);
        end
        tick();
        checks++;
        if (irq_v[0] !== 1'b0) begin
            failures++; $display("FAIL mid_irq_after got=%b exp=0", irq_v[0]);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            reset      = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 3) == 0) in_port = 8'($urandom);
            chipselect = 1'($urandom);
            write_n    = 1'($urandom);
            address    = 2'($urandom);
            writedata  = $urandom;
            tick();
            for (int m = 0; m < 3; m++) begin
                checks++;
                if (rd[m] !== m_rd[m] || irq_v[m] !== m_irq[m]) begin
                    failures++;
                    $display("FAIL random_dut%0d cyc=%0d got=%h/%b exp=%h/%b", m, i, rd[m], irq_v[m], m_rd[m], m_irq[m]);
                end
            end
        end
        reset = 1'b0; chipselect = 1'b0; write_n = 1'b1;
    endtask

    initial begin
        for (int m = 0; m < 3; m++) begin
            m_cap[m] = 8'd0;
            m_rd[m]  = 32'd0;
        end
        reset = 1'b1; address = 2'd0; chipselect = 1'b0; write_n = 1'b1;
        writedata = 32'd0; in_port = 8'd0;
        #1;
        test_reset();
        test_rising_irq();
        test_masked();
        test_collision();
        test_modes();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
